// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Purpose:
//   Lets the instruction-fetch port and the data-access port share one
//   single-port synchronous memory. Only one access is in flight at a time.
//   The memory answers a fixed MEM_LATENCY cycles after the issue strobe.
//   Data accesses normally win arbitration. A starvation counter forces a
//   fetch grant after STARVE_LIMIT back-to-back data grants while fetch waits.
//   A fetch flush (taken jump) lets the in-flight fetch finish at the memory
//   but suppresses its ack.
//
// Ports:
//   clk, rst_n               clock, synchronous active-low reset
//   if_req/if_addr/if_flush  fetch request, byte address, flush (jump taken)
//   if_ack/if_rdata          1-cycle fetch ack, fetch data (valid with ack)
//   d_req/d_addr/d_we/d_be/d_wdata
//                            data request, address, write flag, byte enables,
//                            write data
//   d_ack/d_rdata            1-cycle data ack, read data (valid with ack, reads)
//   mem_en/mem_we/mem_addr/mem_be/mem_wdata
//                            registered issue strobe and access fields
//   mem_rdata                memory read data, valid MEM_LATENCY cycles after
//                            mem_en
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int MEM_LATENCY  = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    input  logic        if_flush,
    output logic        if_ack,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic [31:0] d_addr,
    input  logic        d_we,
    input  logic [3:0]  d_be,
    input  logic [31:0] d_wdata,
    output logic        d_ack,
    output logic [31:0] d_rdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam int LAT_W    = $clog2(MEM_LATENCY + 1);
    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    typedef enum logic [1:0] {
        OWNER_NONE,
        OWNER_FETCH,
        OWNER_DATA
    } owner_t;

    state_t              state_q, state_d;
    owner_t              owner_q, owner_d;
    logic [LAT_W-1:0]    lat_cnt_q, lat_cnt_d;
    logic [STARVE_W-1:0] starve_cnt_q, starve_cnt_d;
    logic                flushed_q, flushed_d;
    logic                if_ack_q, if_ack_d;
    logic                d_ack_q, d_ack_d;
    logic                mem_en_q, mem_en_d;
    logic                mem_we_q, mem_we_d;
    logic [31:0]         mem_addr_q, mem_addr_d;
    logic [3:0]          mem_be_q, mem_be_d;
    logic [31:0]         mem_wdata_q, mem_wdata_d;

    logic                fetch_ok;
    logic                fetch_forced;
    logic                grant_fetch;
    logic                grant_data;

    // Next-state logic. The BUSY state counts the latency down from
    // MEM_LATENCY; on the 1 -> 0 step the owner's ack is registered and the
    // FSM drops back to IDLE, so the ack cycle is already an IDLE cycle and
    // the next grant can be decided there (one access per MEM_LATENCY+1).
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        lat_cnt_d    = lat_cnt_q;
        starve_cnt_d = starve_cnt_q;
        flushed_d    = flushed_q;
        if_ack_d     = 1'b0;
        d_ack_d      = 1'b0;
        mem_en_d     = 1'b0;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_be_d     = mem_be_q;
        mem_wdata_d  = mem_wdata_q;
        grant_fetch  = 1'b0;
        grant_data   = 1'b0;

        // A fetch raised together with a flush is already stale.
        fetch_ok     = if_req && !if_flush;
        fetch_forced = if_req && (starve_cnt_q == STARVE_W'(STARVE_LIMIT));

        case (state_q)
            IDLE: begin
                if (d_req && !(fetch_ok && fetch_forced)) begin
                    grant_data = 1'b1;
                end else if (fetch_ok) begin
                    grant_fetch = 1'b1;
                end
            end
            BUSY: begin
                lat_cnt_d = lat_cnt_q - LAT_W'(1);
                if (owner_q == OWNER_FETCH && if_flush) begin
                    flushed_d = 1'b1;
                end
                if (lat_cnt_q == LAT_W'(1)) begin
                    // A flush arriving in this very cycle must still kill the ack.
                    if_ack_d  = (owner_q == OWNER_FETCH) && !flushed_q && !if_flush;
                    d_ack_d   = (owner_q == OWNER_DATA);
                    state_d   = IDLE;
                    owner_d   = OWNER_NONE;
                    flushed_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (grant_data) begin
            state_d     = BUSY;
            owner_d     = OWNER_DATA;
            lat_cnt_d   = LAT_W'(MEM_LATENCY);
            flushed_d   = 1'b0;
            mem_en_d    = 1'b1;
            mem_we_d    = d_we;
            mem_addr_d  = d_addr;
            mem_be_d    = d_be;
            mem_wdata_d = d_wdata;
        end else if (grant_fetch) begin
            state_d    = BUSY;
            owner_d    = OWNER_FETCH;
            lat_cnt_d  = LAT_W'(MEM_LATENCY);
            flushed_d  = 1'b0;
            mem_en_d   = 1'b1;
            mem_addr_d = if_addr;
            mem_be_d   = 4'hF;
        end

        // Counts data grants that jumped ahead of a waiting fetch.
        if (!if_req || grant_fetch) begin
            starve_cnt_d = '0;
        end else if (grant_data && (starve_cnt_q != STARVE_W'(STARVE_LIMIT))) begin
            starve_cnt_d = starve_cnt_q + STARVE_W'(1);
        end
    end

    // State and output registers; a synchronous reset aborts any access.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            owner_q      <= OWNER_NONE;
            lat_cnt_q    <= '0;
            starve_cnt_q <= '0;
            flushed_q    <= 1'b0;
            if_ack_q     <= 1'b0;
            d_ack_q      <= 1'b0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_be_q     <= '0;
            mem_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            lat_cnt_q    <= lat_cnt_d;
            starve_cnt_q <= starve_cnt_d;
            flushed_q    <= flushed_d;
            if_ack_q     <= if_ack_d;
            d_ack_q      <= d_ack_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_be_q     <= mem_be_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    assign if_ack    = if_ack_q;
    assign d_ack     = d_ack_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_be    = mem_be_q;
    assign mem_wdata = mem_wdata_q;
    assign if_rdata  = mem_rdata;
    assign d_rdata   = mem_rdata;

    // A waiting fetch (no ack, no flush) must hold its request and address.
    a_if_stable: assert property (@(posedge clk) disable iff (!rst_n)
        ($past(if_req) && !$past(if_ack_q) && !$past(if_flush) && !if_ack_q)
            |-> (if_req && (if_addr == $past(if_addr))));

    // A waiting data request must hold all of its fields until acked.
    a_d_stable: assert property (@(posedge clk) disable iff (!rst_n)
        ($past(d_req) && !$past(d_ack_q) && !d_ack_q)
            |-> (d_req && (d_addr == $past(d_addr)) && (d_we == $past(d_we)) &&
                 (d_be == $past(d_be)) && (d_wdata == $past(d_wdata))));

    a_one_ack: assert property (@(posedge clk) !(if_ack_q && d_ack_q));

    a_we_with_en: assert property (@(posedge clk) !(mem_we_q && !mem_en_q));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Randomized bench for mem_port_arbiter (MEM_LATENCY=2, STARVE_LIMIT=3).
// A small memory answers the DUT's issue strobes. A transaction-level model
// predicts, for each cycle, whether an issue or an ack is due and with which
// address, enables and data. Phases alternate between sparse traffic with
// flushes and saturated traffic where both ports re-request every time.
// Resets are fired in the middle of accesses.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int LAT        = 2;
    localparam int LIMIT      = 3;
    localparam int NUM_CYCLES = 3000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_flush;
    logic        if_ack;
    logic [31:0] if_rdata;
    logic        d_req;
    logic [31:0] d_addr;
    logic        d_we;
    logic [3:0]  d_be;
    logic [31:0] d_wdata;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int checkCount = 0;
    int errorCount = 0;
    int cycle      = 0;

    // Bench-side memory driven by the DUT, and the model's view of it.
    logic [31:0] memArr   [64];
    logic [31:0] modelMem [64];
    logic [31:0] rdData   [16];
    bit          rdValid  [16];

    // Model of the single in-flight access.
    int          freeAt;
    int          issueAt;
    int          ackAt;
    int          ackOwner;       // 0 none, 1 fetch, 2 data
    bit          ackFlushed;
    int          starveCnt;
    logic [31:0] expAddr;
    logic        expWe;
    logic [3:0]  expBe;
    logic [31:0] expWdata;
    logic [31:0] expRdata;

    // Requester state.
    bit          ifActive;
    bit          ifDropNext;
    logic [31:0] ifAddrReg;
    bit          dActive;
    int          resetHold;
    int          nextResetAt;
    bit          prevRstLow;

    mem_port_arbiter #(
        .MEM_LATENCY (LAT),
        .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_flush (if_flush),
        .if_ack   (if_ack),
        .if_rdata (if_rdata),
        .d_req    (d_req),
        .d_addr   (d_addr),
        .d_we     (d_we),
        .d_be     (d_be),
        .d_wdata  (d_wdata),
        .d_ack    (d_ack),
        .d_rdata  (d_rdata),
        .mem_en   (mem_en),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_be   (mem_be),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mergeBytes(input logic [31:0] oldWord,
                                               input logic [31:0] newWord,
                                               input logic [3:0]  be);
        logic [31:0] result;
        result = oldWord;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) result[b*8 +: 8] = newWord[b*8 +: 8];
        end
        return result;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            if (errorCount <= 40)
                $display("[TB] FAIL %s at cycle %0d: got 0x%08h, expected 0x%08h",
                         tag, cycle, observed, expected);
        end
    endtask

    // Drives reset and both requesters for the current cycle. Requesters only
    // change in their ack cycle (new request or drop) or right after a flush.
    task automatic applyStimulus(input bit ifAckNow, input bit dAckNow);
        bit sat;
        sat = ((cycle / 400) % 3) == 1;

        if (cycle < 3) begin
            rst_n = 1'b0;
        end else if (resetHold > 0) begin
            rst_n = 1'b0;
            resetHold--;
        end else if (cycle >= nextResetAt && issueAt >= 0 &&
                     cycle >= issueAt && cycle < ackAt) begin
            rst_n       = 1'b0;
            resetHold   = 1;
            nextResetAt = nextResetAt + 700;
        end else begin
            rst_n = 1'b1;
        end

        if_flush = 1'b0;
        if (rst_n) begin
            if (ifAckNow)   ifActive = 1'b0;
            if (ifDropNext) begin
                ifActive   = 1'b0;
                ifDropNext = 1'b0;
            end
            if (!ifActive && (sat || $urandom_range(99) < 45)) begin
                ifActive  = 1'b1;
                ifAddrReg = $urandom & 32'hFFFF_FFFC;
            end else if (ifActive && !ifAckNow && !sat && $urandom_range(99) < 8) begin
                if_flush   = 1'b1;
                ifDropNext = 1'b1;
            end

            if (dAckNow) dActive = 1'b0;
            if (!dActive && (sat || $urandom_range(99) < 40)) begin
                dActive = 1'b1;
                d_addr  = $urandom & 32'hFFFF_FFFC;
                d_we    = ($urandom_range(99) < 40);
                d_be    = 4'($urandom_range(15));
                d_wdata = $urandom;
            end
        end

        if_req  = ifActive;
        if_addr = ifAddrReg;
        d_req   = dActive;
    endtask

    initial begin
        int  slot;
        int  idx;
        bit  expEn;
        bit  expIfAck;
        bit  expDAck;
        bit  grantD;
        bit  grantF;
        bit  fetchOk;

        rst_n     = 1'b0;
        if_req    = 1'b0;
        if_addr   = '0;
        if_flush  = 1'b0;
        d_req     = 1'b0;
        d_addr    = '0;
        d_we      = 1'b0;
        d_be      = '0;
        d_wdata   = '0;
        mem_rdata = '0;
        for (int i = 0; i < 64; i++) begin
            memArr[i]   = (32'(i) * 32'h0101_0101) ^ 32'hC0DE_0000;
            modelMem[i] = (32'(i) * 32'h0101_0101) ^ 32'hC0DE_0000;
        end
        for (int i = 0; i < 16; i++) rdValid[i] = 1'b0;
        freeAt      = 0;
        issueAt     = -1;
        ackAt       = -1;
        ackOwner    = 0;
        ackFlushed  = 1'b0;
        starveCnt   = 0;
        ifActive    = 1'b0;
        ifDropNext  = 1'b0;
        ifAddrReg   = '0;
        dActive     = 1'b0;
        resetHold   = 0;
        nextResetAt = 700;
        prevRstLow  = 1'b1;
        expAddr     = '0;
        expWe       = 1'b0;
        expBe       = '0;
        expWdata    = '0;
        expRdata    = '0;

        for (cycle = 0; cycle < NUM_CYCLES; cycle++) begin
            @(posedge clk);
            #1;

            // Memory: return scheduled read data, accept this cycle's issue.
            slot      = cycle % 16;
            mem_rdata = rdValid[slot] ? rdData[slot] : $urandom;
            rdValid[slot] = 1'b0;
            if (mem_en === 1'b1) begin
                idx = int'(mem_addr[7:2]);
                rdData[(cycle + LAT) % 16]  = memArr[idx];
                rdValid[(cycle + LAT) % 16] = 1'b1;
                if (mem_we === 1'b1) memArr[idx] = mergeBytes(memArr[idx], mem_wdata, mem_be);
            end

            expEn    = (issueAt == cycle);
            expIfAck = (ackAt == cycle) && (ackOwner == 1) && !ackFlushed;
            expDAck  = (ackAt == cycle) && (ackOwner == 2);

            applyStimulus(expIfAck, expDAck);
            #1;

            checkOutput("mem_en", 32'(mem_en), 32'(expEn));
            checkOutput("if_ack", 32'(if_ack), 32'(expIfAck));
            checkOutput("d_ack", 32'(d_ack), 32'(expDAck));
            checkOutput("mem_we", 32'(mem_we), expEn ? 32'(expWe) : 32'd0);
            if (expEn) begin
                checkOutput("mem_addr", mem_addr, expAddr);
                checkOutput("mem_be", 32'(mem_be), 32'(expBe));
                if (expWe) checkOutput("mem_wdata", mem_wdata, expWdata);
            end
            if (prevRstLow) begin
                checkOutput("rst_mem_addr", mem_addr, 32'd0);
                checkOutput("rst_mem_be", 32'(mem_be), 32'd0);
                checkOutput("rst_mem_wdata", mem_wdata, 32'd0);
            end
            if (expIfAck) checkOutput("if_rdata", if_rdata, expRdata);
            if (expDAck && !expWe) checkOutput("d_rdata", d_rdata, expRdata);

            // Model update from this cycle's inputs.
            if (!rst_n) begin
                freeAt    = cycle + 1;
                issueAt   = -1;
                ackAt     = -1;
                ackOwner  = 0;
                starveCnt = 0;
            end else begin
                if (ackOwner == 1 && if_flush && cycle >= issueAt && cycle < ackAt)
                    ackFlushed = 1'b1;
                grantD = 1'b0;
                grantF = 1'b0;
                if (cycle >= freeAt) begin
                    fetchOk = if_req && !if_flush;
                    if (d_req && !(fetchOk && starveCnt == LIMIT)) grantD = 1'b1;
                    else if (fetchOk)                              grantF = 1'b1;
                end
                if (!if_req || grantF)             starveCnt = 0;
                else if (grantD && starveCnt < LIMIT) starveCnt++;
                if (grantD || grantF) begin
                    issueAt    = cycle + 1;
                    ackAt      = cycle + 1 + LAT;
                    freeAt     = ackAt;
                    ackFlushed = 1'b0;
                    ackOwner   = grantD ? 2 : 1;
                    expAddr    = grantD ? d_addr : if_addr;
                    expWe      = grantD && d_we;
                    expBe      = grantD ? d_be : 4'hF;
                    expWdata   = d_wdata;
                    idx        = int'(expAddr[7:2]);
                    expRdata   = modelMem[idx];
                    if (expWe) modelMem[idx] = mergeBytes(modelMem[idx], d_wdata, d_be);
                end
            end
            prevRstLow = !rst_n;
        end

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
